uart_tx_sequencer: RTL and testbench
====================================

# uart_tx_sequencer

Autonomous transmit front-end for the AXI-lite UART slave. Accepts a byte stream from the core/kernel side over a valid/ready handshake and buffers it in a small FIFO. Drains the FIFO into the UART by polling its status register and writing its TX data register over an AXI-lite master port. Software no longer spin-polls the UART for console output.

## Interface
Parameters:
- DEPTH, 16: byte FIFO depth; power of two, ≥2.
- STAT_ADDR, 16'h0008: UART status register offset.
- TX_ADDR, 16'h0004: UART TX data register offset.
- TXFULL_BIT, 3: bit index of "TX FIFO full" in the status word.
- POLL_GAP, 8: idle cycles between a status read that reports full and the next status read; ≥1.

Ports:
- clk  in  1  clock; same clock as the UART.
- rstn  in  1  reset; synchronous, active-low.
- in_valid  in  1  byte offered.
- in_ready  out  1  FIFO can accept.
- in_data  in  8  byte.
- m_awaddr  out  16  write address; always TX_ADDR.
- m_awvalid  out  1
- m_awready  in  1
- m_wdata  out  32  {24'b0, byte}.
- m_wvalid  out  1
- m_wready  in  1
- m_bresp  in  2
- m_bvalid  in  1
- m_bready  out  1
- m_araddr  out  16  always STAT_ADDR.
- m_arvalid  out  1
- m_arready  in  1
- m_rdata  in  32
- m_rresp  in  2
- m_rvalid  in  1
- m_rready  out  1
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE, or level≠0.
- err  out  1  sticky; set on any non-OKAY rresp/bresp.
- err_clr  in  1  clears err.

## Operation
- FIFO push when in_valid && in_ready. in_ready = (level≠DEPTH). No push–pop bypass when full.
- FSM states: IDLE, RD_ADDR, RD_DATA, BACKOFF, WR, WR_RESP.
- IDLE: if level≠0, go to RD_ADDR.
- RD_ADDR: m_arvalid=1. Hold it until m_arready, then go to RD_DATA.
- RD_DATA: m_rready=1. On m_rvalid:
  - rresp≠OKAY: set err, go to BACKOFF.
  - m_rdata[TXFULL_BIT]=1: go to BACKOFF.
  - Otherwise: go to WR.
- BACKOFF: count POLL_GAP cycles, then go to RD_ADDR.
- WR:
  - Enter with m_awvalid=m_wvalid=1.
  - Each valid drops independently on its own handshake. Both may complete in the same cycle.
  - m_wdata is the FIFO head byte, stable throughout WR.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP: m_bready=1. On m_bvalid: pop the FIFO head. If bresp≠OKAY, also set err (the byte is dropped, not retried). Go to IDLE.
- err: set has priority over err_clr in the same cycle.
- Width rules:
  - level is a $clog2(DEPTH)+1-bit counter. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Push and pop in the same cycle leave level unchanged.
- Reset (any state, including mid-transaction):
  - FSM to IDLE; FIFO emptied; err=0; BACKOFF counter=0.
  - All m_*valid and m_*ready =0.
  - in_ready=0 during reset, 1 from the first cycle after rstn rises.
  - The UART shares rstn, so no AXI transaction is left dangling.

## Timing
- All outputs are registered except in_ready and level (combinational from the FIFO counter).
- A push at edge T into an empty, idle block puts m_arvalid high in cycle T+1.
- With zero-wait-state slaves and status not-full, one byte costs 6 cycles: IDLE→RD_ADDR→RD_DATA→WR→WR_RESP→IDLE.
- The FIFO pop is visible in level one cycle after the bvalid handshake edge.
- AXI rules:
  - A valid, once asserted, is never deasserted before its ready.
  - Address and data are stable while valid is high.
  - There is never more than one outstanding read or write.
  - A read and a write are never in flight at the same time.

## Structure
- Package uart_ctrl_pkg holds:
  - State enum.
  - AXI resp codes (OKAY=2'b00).
  - Default register offsets and TXFULL_BIT.
- One sub-module, sync_fifo, parameterised by WIDTH=8 and DEPTH. It provides push, pop, head, level and full/empty.
- The FSM and AXI-lite master logic live in uart_tx_sequencer.

## Test plan
- **Single byte:** push 8'h41, status reads 0. Expect:
  - ar to 0x0008.
  - One write to 0x0004 with wdata 32'h00000041.
  - level 1→0; busy low after 6 cycles.
- **Full backpressure:** push DEPTH+1 bytes back-to-back with arready held low. Expect in_ready=0 exactly at level=16; the 17th byte is not accepted until the first pop.
- **TX-full polling:** status returns 32'h00000008 three times, then 0. Expect:
  - Three BACKOFF periods of exactly 8 cycles each.
  - Then a single write; no write issued while full.
- **Skewed handshakes:** awready arrives 3 cycles before wready, then the reverse. Expect awvalid and wvalid each to drop on their own handshake, and exactly one write response consumed per byte.
- **Error path:** bresp=2'b10 on byte 8'h55. Expect:
  - err=1 and the byte is popped (not rewritten).
  - err_clr in the same cycle as a new rresp=2'b10 leaves err=1.
- **Reset mid-write:** deassert rstn while in WR with awvalid=1 and level=5. Next cycle: all valids 0, level=0, err=0, FSM IDLE.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit sequencer.
// Holds the FSM state enum, AXI response codes and the default UART register map.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StBackoff,
        StWr,
        StWrResp
    } tx_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [15:0] DEF_STAT_ADDR  = 16'h0008;
    localparam logic [15:0] DEF_TX_ADDR    = 16'h0004;
    localparam int unsigned DEF_TXFULL_BIT = 3;

    function automatic logic resp_ok(input logic [1:0] resp);
        return resp == RESP_OKAY;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy counter and a show-ahead head output.
// Push while full and pop while empty are ignored; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [LW-1:0]    cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == FULL_LVL);
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign level   = cnt_q;
    assign head    = mem_q[rptr_q];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Buffers console bytes and drains them into the AXI-lite UART: poll status, back off while
// the UART TX FIFO is full, otherwise write one byte and wait for its response.
module uart_tx_sequencer
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter logic [15:0] STAT_ADDR  = DEF_STAT_ADDR,
    parameter logic [15:0] TX_ADDR    = DEF_TX_ADDR,
    parameter int unsigned TXFULL_BIT = DEF_TXFULL_BIT,
    parameter int unsigned POLL_GAP   = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic [15:0]            m_awaddr,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [31:0]            m_wdata,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [1:0]             m_bresp,
    input  logic                   m_bvalid,
    output logic                   m_bready,
    output logic [15:0]            m_araddr,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    input  logic [31:0]            m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    tx_state_e     state_q;
    logic [GW-1:0] gap_q;
    logic          ready_en_q;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          aw_fire;
    logic          w_fire;
    logic          idle_hold;
    logic [LW-1:0] level_nxt;
    logic          unused_rdata;

    assign m_awaddr     = TX_ADDR;
    assign m_araddr     = STAT_ADDR;
    assign unused_rdata = ^m_rdata;

    // in_ready stays low through reset and rises one edge after rstn is released.
    assign in_ready  = ready_en_q && !fifo_full;
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == StWrResp) && m_bready && m_bvalid;
    assign aw_fire   = m_awvalid && m_awready;
    assign w_fire    = m_wvalid && m_wready;
    assign idle_hold = (state_q == StIdle) && fifo_empty;
    assign level_nxt = level + LW'(push) - LW'(pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .head  (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            gap_q      <= '0;
            ready_en_q <= 1'b0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_wdata    <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            // Next state is idle only when idling empty or finishing a write response.
            busy       <= (level_nxt != '0) || !(idle_hold || pop);
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q   <= StRdAddr;
                        m_arvalid <= 1'b1;
                    end
                end
                StRdAddr: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (m_rvalid) begin
                        m_rready <= 1'b0;
                        if (!resp_ok(m_rresp)) begin
                            err     <= 1'b1;
                            state_q <= StBackoff;
                        end else if (m_rdata[TXFULL_BIT]) begin
                            state_q <= StBackoff;
                        end else begin
                            state_q   <= StWr;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            m_wdata   <= {24'b0, head};
                        end
                    end
                end
                StBackoff: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q     <= '0;
                        state_q   <= StRdAddr;
                        m_arvalid <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                StWr: begin
                    if (aw_fire) begin
                        m_awvalid <= 1'b0;
                    end
                    if (w_fire) begin
                        m_wvalid <= 1'b0;
                    end
                    if ((aw_fire || !m_awvalid) && (w_fire || !m_wvalid)) begin
                        state_q  <= StWrResp;
                        m_bready <= 1'b1;
                    end
                end
                StWrResp: begin
                    // A failed write still retires the byte; it is never retried.
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
                        state_q  <= StIdle;
                        if (!resp_ok(m_bresp)) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer with a behavioural AXI-lite UART slave and a
// byte scoreboard checked on every write-data handshake.
module tb_uart_tx_sequencer;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned POLL_GAP = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [15:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [15:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  m_rresp = 2'b00;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [4:0]  level;
    logic        busy;
    logic        err;
    logic        err_clr;

    int n_vec = 0;
    int n_err = 0;
    int n_ar = 0;
    int n_wr = 0;
    int n_b = 0;

    logic [7:0]  sb_q[$];
    logic [31:0] stat_q[$];
    logic [1:0]  rresp_q[$];
    int          gap_q[$];

    bit         ar_block = 1'b0;
    int         aw_delay = 0;
    int         w_delay = 0;
    logic [1:0] bresp_k = 2'b00;

    uart_tx_sequencer #(
        .DEPTH      (DEPTH),
        .STAT_ADDR  (16'h0008),
        .TX_ADDR    (16'h0004),
        .TXFULL_BIT (3),
        .POLL_GAP   (POLL_GAP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .level     (level),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (in_ready) sb_q.push_back(b);
        else chk("push_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (busy && cyc < bound);
        chk("idle_reached", 32'(busy), 32'd0);
        step();
    endtask

    // UART slave: handshakes predicted on one negedge are applied on the next.
    initial begin : slave
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_seen, w_seen, bo_arm;
        int aw_cnt, w_cnt, gap;
        logic [31:0] exp_w;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        aw_seen = 0; w_seen = 0; bo_arm = 0; aw_cnt = 0; w_cnt = 0; gap = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
                aw_seen = 0; w_seen = 0; bo_arm = 0; aw_cnt = 0; w_cnt = 0;
                m_arready = 0; m_awready = 0; m_wready = 0; m_rvalid = 0; m_bvalid = 0;
                continue;
            end
            if (ar_hs) begin
                n_ar++;
                m_rvalid = 1'b1;
                m_rdata  = 32'h0;
                m_rresp  = 2'b00;
                if (stat_q.size() != 0) m_rdata = stat_q.pop_front();
                if (rresp_q.size() != 0) m_rresp = rresp_q.pop_front();
            end
            if (r_hs) begin
                m_rvalid = 1'b0;
                if (m_rdata[3] || m_rresp != 2'b00) begin
                    bo_arm = 1;
                    gap = 0;
                end
            end
            if (aw_hs) aw_seen = 1;
            if (w_hs) w_seen = 1;
            if (aw_hs) begin
                chk("aw_drop", 32'(m_awvalid), 32'd0);
                if (!w_seen) chk("w_hold", 32'(m_wvalid), 32'd1);
            end
            if (w_hs) begin
                chk("w_drop", 32'(m_wvalid), 32'd0);
                if (!aw_seen) chk("aw_hold", 32'(m_awvalid), 32'd1);
            end
            if (aw_seen && w_seen) begin
                n_wr++;
                m_bvalid = 1'b1;
                m_bresp  = bresp_k;
                aw_seen  = 0;
                w_seen   = 0;
            end
            if (b_hs) begin
                m_bvalid = 1'b0;
                n_b++;
            end
            if (bo_arm) begin
                if (m_arvalid) begin
                    gap_q.push_back(gap);
                    bo_arm = 0;
                end else begin
                    gap++;
                end
            end
            m_arready = !ar_block;
            if (m_awvalid) begin
                m_awready = (aw_cnt >= aw_delay);
                aw_cnt++;
            end else begin
                m_awready = 1'b0;
                aw_cnt = 0;
            end
            if (m_wvalid) begin
                m_wready = (w_cnt >= w_delay);
                w_cnt++;
            end else begin
                m_wready = 1'b0;
                w_cnt = 0;
            end
            ar_hs = m_arvalid && m_arready;
            r_hs  = m_rvalid && m_rready;
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            if (ar_hs) chk("araddr", 32'(m_araddr), 32'h8);
            if (aw_hs) chk("awaddr", 32'(m_awaddr), 32'h4);
            if (w_hs) begin
                exp_w = 32'hxxxx_xxxx;
                if (sb_q.size() != 0) exp_w = {24'h0, sb_q.pop_front()};
                chk("wdata", m_wdata, exp_w);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cyc, t, n0, a0, b0;
        rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; err_clr = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_level", 32'(level), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("post_rst_valids", 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 32'd0);

        // Single byte, zero-wait slave.
        push_byte(8'h41);
        chk("single_level", 32'(level), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_ar_early", 32'(m_arvalid), 32'd0);
        step();
        chk("single_ar_latency", 32'(m_arvalid), 32'd1);
        wait_idle(100, cyc);
        // Busy drops on the fifth edge after the push edge: six cycles including the push.
        chk("single_busy_cycles", 32'(cyc + 1), 32'd5);
        chk("single_level_after", 32'(level), 32'd0);
        chk("single_ar_count", 32'(n_ar), 32'd1);
        chk("single_wr_count", 32'(n_wr), 32'd1);
        chk("single_b_count", 32'(n_b), 32'd1);

        // Full backpressure with the status read stalled.
        ar_block = 1'b1;
        n0 = n_wr;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h80 + i));
        chk("full_level", 32'(level), 32'd16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h11;
        repeat (4) step();
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        chk("full_hold_level", 32'(level), 32'd16);
        chk("full_ar_held", 32'(m_arvalid), 32'd1);
        ar_block = 1'b0;
        t = 0;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        chk("full_release_ready", 32'(in_ready), 32'd1);
        chk("full_release_level", 32'(level), 32'd15);
        chk("full_release_writes", 32'(n_wr - n0), 32'd1);
        sb_q.push_back(8'h11);
        step();
        in_valid = 1'b0;
        wait_idle(400, cyc);
        chk("full_drain_writes", 32'(n_wr - n0), 32'd17);
        chk("full_drain_sb", 32'(sb_q.size()), 32'd0);
        chk("full_drain_level", 32'(level), 32'd0);

        // TX-full polling.
        gap_q.delete();
        n0 = n_wr;
        a0 = n_ar;
        stat_q = '{32'h8, 32'h8, 32'h8, 32'h0};
        push_byte(8'h5A);
        wait_idle(300, cyc);
        chk("poll_backoffs", 32'(gap_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("poll_gap", 32'(gap_q[i]), 32'(POLL_GAP));
        chk("poll_reads", 32'(n_ar - a0), 32'd4);
        chk("poll_writes", 32'(n_wr - n0), 32'd1);

        // Skewed write handshakes.
        b0 = n_b;
        aw_delay = 0; w_delay = 3;
        push_byte(8'h33);
        wait_idle(100, cyc);
        chk("skew_aw_first_b", 32'(n_b - b0), 32'd1);
        aw_delay = 3; w_delay = 0;
        push_byte(8'hCC);
        wait_idle(100, cyc);
        chk("skew_w_first_b", 32'(n_b - b0), 32'd2);
        aw_delay = 0; w_delay = 0;

        // Error path: failed write response retires the byte.
        bresp_k = 2'b10;
        n0 = n_wr;
        push_byte(8'h55);
        wait_idle(100, cyc);
        bresp_k = 2'b00;
        chk("bresp_err", 32'(err), 32'd1);
        chk("bresp_level", 32'(level), 32'd0);
        repeat (5) step();
        chk("bresp_no_rewrite", 32'(n_wr - n0), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'd0);

        // err_clr coincides with a failed status read on the third edge after the push.
        rresp_q.push_back(2'b10);
        n0 = n_wr;
        push_byte(8'h66);
        step();
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_set_wins", 32'(err), 32'd1);
        wait_idle(200, cyc);
        chk("rresp_retry_write", 32'(n_wr - n0), 32'd1);

        // Reset in the middle of a stalled write.
        chk("pre_rst_err", 32'(err), 32'd1);
        aw_delay = 20; w_delay = 20;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        t = 0;
        while (!(m_awvalid && level == 5'd5) && t < 50) begin
            step();
            t++;
        end
        chk("pre_rst_awvalid", 32'(m_awvalid), 32'd1);
        chk("pre_rst_level", 32'(level), 32'd5);
        rstn = 1'b0;
        step();
        chk("mid_rst_valids", 32'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rstn = 1'b1;
        sb_q.delete();
        aw_delay = 0; w_delay = 0;
        step();
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        n0 = n_wr;
        push_byte(8'h7E);
        wait_idle(100, cyc);
        chk("after_rst_write", 32'(n_wr - n0), 32'd1);
        chk("after_rst_level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
